// File: rtl/xosera_host_bus_master.sv
// Host initiator for the Xosera 8-bit register bus: one 16-bit register access becomes two byte cycles
// (even byte [15:8] first). Every output is registered; the odd-byte write triggers the register side effect.
module xosera_host_bus_master #(
  parameter int CS_CYCLES  = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rnw_i,
  input  logic [3:0]  req_reg_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  localparam int MAX_CYC = (CS_CYCLES > GAP_CYCLES) ? CS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CS_LOAD  = CNT_W'(CS_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (CS_CYCLES < 1) begin : g_bad_cs
      $error("CS_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("GAP_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             byte1, byte1_nx;
  logic [7:0]       wr_lo, wr_lo_nx;
  logic [7:0]       rd_hi, rd_hi_nx;
  logic [7:0]       rd_lo, rd_lo_nx;

  logic             ready_nx, rsp_valid_nx, cs_n_nx, rd_nwr_nx, bytesel_nx, oe_nx;
  logic [15:0]      rsp_data_nx;
  logic [3:0]       reg_num_nx;
  logic [7:0]       data_nx;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    byte1_nx     = byte1;
    wr_lo_nx     = wr_lo;
    rd_hi_nx     = rd_hi;
    rd_lo_nx     = rd_lo;
    ready_nx     = 1'b0;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = rsp_data_o;
    cs_n_nx      = 1'b1;
    rd_nwr_nx    = bus_rd_nwr_o;
    reg_num_nx   = bus_reg_num_o;
    bytesel_nx   = bus_bytesel_o;
    data_nx      = bus_data_o;
    oe_nx        = bus_data_oe_o;

    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (req_valid_i && req_ready_o) begin
          // Address, direction and even byte go out now; only the odd write byte is kept aside.
          state_nx   = SETUP;
          byte1_nx   = 1'b0;
          wr_lo_nx   = req_data_i[7:0];
          ready_nx   = 1'b0;
          rd_nwr_nx  = req_rnw_i;
          reg_num_nx = req_reg_i;
          bytesel_nx = 1'b0;
          data_nx    = req_rnw_i ? 8'h00 : req_data_i[15:8];
          oe_nx      = ~req_rnw_i;
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = CS_LOAD;
        cs_n_nx  = 1'b0;
      end
      STROBE: begin
        if (cnt == CNT_ONE) begin
          state_nx = HOLD;
          cnt_nx   = GAP_LOAD;
          if (byte1) rd_lo_nx = bus_data_i;
          else       rd_hi_nx = bus_data_i;
        end else begin
          cnt_nx  = cnt - CNT_ONE;
          cs_n_nx = 1'b0;
        end
      end
      HOLD: begin
        if (cnt != CNT_ONE) begin
          cnt_nx = cnt - CNT_ONE;
        end else if (!byte1) begin
          // Straight into the odd byte; oe is left asserted so the pins are never released mid-word.
          state_nx   = SETUP;
          byte1_nx   = 1'b1;
          bytesel_nx = 1'b1;
          data_nx    = bus_rd_nwr_o ? 8'h00 : wr_lo;
        end else begin
          state_nx     = DONE;
          rsp_valid_nx = 1'b1;
          if (bus_rd_nwr_o) rsp_data_nx = {rd_hi, rd_lo};
          rd_nwr_nx    = 1'b1;
          reg_num_nx   = 4'h0;
          bytesel_nx   = 1'b0;
          data_nx      = 8'h00;
          oe_nx        = 1'b0;
        end
      end
      DONE: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      byte1         <= 1'b0;
      wr_lo         <= 8'h00;
      rd_hi         <= 8'h00;
      rd_lo         <= 8'h00;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= 16'h0000;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= 4'h0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= 8'h00;
      bus_data_oe_o <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      byte1         <= byte1_nx;
      wr_lo         <= wr_lo_nx;
      rd_hi         <= rd_hi_nx;
      rd_lo         <= rd_lo_nx;
      req_ready_o   <= ready_nx;
      rsp_valid_o   <= rsp_valid_nx;
      rsp_data_o    <= rsp_data_nx;
      bus_cs_n_o    <= cs_n_nx;
      bus_rd_nwr_o  <= rd_nwr_nx;
      bus_reg_num_o <= reg_num_nx;
      bus_bytesel_o <= bytesel_nx;
      bus_data_o    <= data_nx;
      bus_data_oe_o <= oe_nx;
    end
  end

endmodule
